// File: rtl/mips_perf_pkg.sv
//------------------------------------------------------------------------------
// Module   : mips_perf_pkg
// Brief    : Shared state encoding and counter-select indices for the perf monitor.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } perf_state_t;

    localparam int SEL_CYCLES     = 0;
    localparam int SEL_EVENT_BASE = 1;

    // Store counter sits directly after the last event channel.
    function automatic int sel_stores(input int nevents);
        return nevents + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/perf_counter.sv
//------------------------------------------------------------------------------
// Module   : perf_counter
// Brief    : Single event counter with sticky overflow and saturate/wrap option.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module perf_counter #(
    parameter int CNTBITS  = 32,
    parameter int SATURATE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [CNTBITS-1:0] count,
    output logic               ovf
);

    localparam logic [CNTBITS-1:0] c_one = {{(CNTBITS-1){1'b0}}, 1'b1};

    logic [CNTBITS-1:0] r_count;
    logic               r_ovf;
    logic               w_full;

    assign w_full = &r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (inc) begin
            if (w_full) begin
                r_ovf <= 1'b1;
                if (SATURATE == 0) begin
                    r_count <= '0;
                end
            end else begin
                r_count <= r_count + c_one;
            end
        end
    end

    assign count = r_count;
    assign ovf   = r_ovf;

endmodule

`default_nettype wire

// File: rtl/mips_perf_monitor.sv
//------------------------------------------------------------------------------
// Module   : mips_perf_monitor
// Brief    : Cycle/event/store performance counters with completion-store freeze.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips_perf_monitor
    import mips_perf_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NEVENTS  = 4,
    parameter int CNTBITS  = 32,
    parameter int SATURATE = 1,
    parameter int ADDRBITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                clear,
    input  logic [NEVENTS-1:0]  events,
    input  logic                memwrite,
    input  logic [WIDTH-1:0]    aluout,
    input  logic [WIDTH-1:0]    writedata,
    input  logic [ADDRBITS-1:0] done_addr,
    input  logic [WIDTH-1:0]    done_data,
    input  logic [4:0]          rd_sel,
    output logic [CNTBITS-1:0]  rd_data,
    output logic [NEVENTS+1:0]  ovf,
    output logic                done,
    output logic                running
);

    localparam int c_ncnt       = NEVENTS + 2;
    localparam int c_sel_stores = sel_stores(NEVENTS);

    perf_state_t                      r_state;
    perf_state_t                      w_state_nxt;
    logic                             w_run;
    logic                             w_match;
    logic [c_ncnt-1:0]                w_inc;
    logic [c_ncnt-1:0][CNTBITS-1:0]   w_counts;
    logic [CNTBITS-1:0]               w_rd_mux;
    logic [CNTBITS-1:0]               r_rd_data;

    // Only the low address bits take part in the completion match.
    generate
        if (ADDRBITS < WIDTH) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^aluout[WIDTH-1:ADDRBITS];
        end
    endgenerate

    assign w_run   = (r_state == ST_RUN);
    assign w_match = w_run && memwrite
                     && (aluout[ADDRBITS-1:0] == done_addr)
                     && (writedata == done_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        running     = 1'b0;
        done        = 1'b0;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (enable) w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (w_match)      w_state_nxt = ST_DONE;
                    else if (!enable) w_state_nxt = ST_PAUSE;
                end
                ST_PAUSE: if (enable) w_state_nxt = ST_RUN;
                ST_DONE:  w_state_nxt = ST_DONE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
        running = (r_state == ST_RUN);
        done    = (r_state == ST_DONE);
    end

    assign w_inc[SEL_CYCLES]   = w_run;
    assign w_inc[c_sel_stores] = w_run & memwrite;

    generate
        for (genvar gi = 0; gi < NEVENTS; gi++) begin : g_event_inc
            assign w_inc[SEL_EVENT_BASE + gi] = w_run & events[gi];
        end

        for (genvar gc = 0; gc < c_ncnt; gc++) begin : g_counter
            perf_counter #(
                .CNTBITS  (CNTBITS),
                .SATURATE (SATURATE)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .clr   (clear),
                .inc   (w_inc[gc]),
                .count (w_counts[gc]),
                .ovf   (ovf[gc])
            );
        end
    endgenerate

    // Unmapped selects fall through to zero.
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < c_ncnt; i++) begin
            if (rd_sel == 5'(i)) begin
                w_rd_mux = w_counts[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_mips_perf_monitor.sv
//------------------------------------------------------------------------------
// Module   : tb_mips_perf_monitor
// Brief    : Directed self-checking bench for mips_perf_monitor.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mips_perf_monitor;

    localparam int NEV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        clear;
    logic [NEV-1:0] events;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [15:0] done_addr;
    logic [31:0] done_data;
    logic [4:0]  rd_sel;

    logic [31:0]    rd_data;
    logic [NEV+1:0] ovf;
    logic           done;
    logic           running;

    logic [3:0]     rd_data_s, rd_data_w;
    logic [NEV+1:0] ovf_s, ovf_w;
    logic           done_s, done_w, running_s, running_w;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_perf_monitor u_dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .events(events),
        .memwrite(memwrite), .aluout(aluout), .writedata(writedata),
        .done_addr(done_addr), .done_data(done_data), .rd_sel(rd_sel),
        .rd_data(rd_data), .ovf(ovf), .done(done), .running(running)
    );

    mips_perf_monitor #(.CNTBITS(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .events(events),
        .memwrite(memwrite), .aluout(aluout), .writedata(writedata),
        .done_addr(done_addr), .done_data(done_data), .rd_sel(rd_sel),
        .rd_data(rd_data_s), .ovf(ovf_s), .done(done_s), .running(running_s)
    );

    mips_perf_monitor #(.CNTBITS(4), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .events(events),
        .memwrite(memwrite), .aluout(aluout), .writedata(writedata),
        .done_addr(done_addr), .done_data(done_data), .rd_sel(rd_sel),
        .rd_data(rd_data_w), .ovf(ovf_w), .done(done_w), .running(running_w)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [4:0] sel);
        rd_sel = sel;
        step(1);
    endtask

    task automatic idle_inputs();
        events    = '0;
        memwrite  = 1'b0;
        aluout    = '0;
        writedata = '0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; clear = 1'b0; rd_sel = '0;
        done_addr = 16'h00C0; done_data = 32'd127;
        idle_inputs();
        step(2);

        // Reset mid-run must discard accumulated counts
        rst = 1'b0; enable = 1'b1;
        step(6);
        rst = 1'b1;
        step(10);
        check_value("rst_running", running, 0);
        check_value("rst_done", done, 0);
        check_value("rst_rd_data", rd_data, 0);
        rst = 1'b0; rd_sel = 5'd0;
        step(1);
        check_value("post_rst_running", running, 1);
        check_value("post_rst_cycles", rd_data, 0);

        // Basic counting over exactly 100 RUN cycles
        clear = 1'b1; step(1); clear = 1'b0;
        check_value("clear_idle", running, 0);
        enable = 1'b1; step(1);
        for (int k = 0; k < 100; k++) begin
            enable    = (k != 99);
            events[0] = (k % 4 == 0);
            events[1] = (k < 7);
            events[2] = (k % 3 == 0);
            events[3] = 1'b0;
            memwrite  = (k % 10 == 0);
            aluout    = 32'h100 + 32'(k);
            writedata = 32'(k);
            step(1);
        end
        idle_inputs(); enable = 1'b0;
        check_value("basic_paused", running, 0);
        check_value("basic_done", done, 0);
        rd(5'd0); check_value("basic_cycles", rd_data, 100);
        rd(5'd1); check_value("basic_ev0", rd_data, 25);
        rd(5'd2); check_value("basic_ev1", rd_data, 7);
        rd(5'd3); check_value("basic_ev2", rd_data, 34);
        rd(5'd4); check_value("basic_ev3", rd_data, 0);
        rd(5'd5); check_value("basic_stores", rd_data, 10);
        rd(5'd31); check_value("rd_sel31", rd_data, 0);
        rd(5'd6); check_value("rd_sel6", rd_data, 0);
        rd(5'd5); check_value("rd_stores_again", rd_data, 10);
        check_value("basic_ovf", 32'(ovf), 0);

        // Completion store at RUN cycle 50, with near misses beforehand
        clear = 1'b1; step(1); clear = 1'b0;
        enable = 1'b1; step(1);
        for (int k = 0; k < 70; k++) begin
            idle_inputs();
            events = 4'b0001;
            if (k == 20) begin
                memwrite = 1'b1; aluout = 32'h00C0; writedata = 32'd126;
            end else if (k == 30) begin
                memwrite = 1'b1; aluout = 32'h00C4; writedata = 32'd127;
            end else if (k == 5 || k == 15 || k == 25 || k == 35 || k == 45) begin
                memwrite = 1'b1; aluout = 32'h0200; writedata = 32'd127;
            end else if (k >= 49) begin
                memwrite = 1'b1; aluout = 32'h00C0; writedata = 32'd127;
                if (k > 49) events = 4'b1111;
            end
            step(1);
            if (k == 20) check_value("near_miss_data", done, 0);
            if (k == 30) check_value("near_miss_addr", done, 0);
            if (k == 48) check_value("pre_match_done", done, 0);
            if (k == 49) begin
                check_value("match_done", done, 1);
                check_value("match_running", running, 0);
            end
        end
        idle_inputs(); enable = 1'b0;
        rd(5'd0); check_value("frozen_cycles", rd_data, 50);
        rd(5'd1); check_value("frozen_ev0", rd_data, 50);
        rd(5'd2); check_value("frozen_ev1", rd_data, 0);
        rd(5'd5); check_value("frozen_stores", rd_data, 8);
        check_value("done_sticky", done, 1);

        // Pause ignores stores and matches; clear beats match
        clear = 1'b1; step(1); clear = 1'b0;
        check_value("clear_done", done, 0);
        enable = 1'b1; step(1);
        for (int k = 0; k < 10; k++) begin
            enable = (k != 9);
            events = 4'b0001; memwrite = 1'b1; aluout = 32'h0300; writedata = 32'(k);
            step(1);
        end
        enable = 1'b0;
        for (int k = 0; k < 30; k++) begin
            events   = 4'b1111;
            memwrite = 1'b1;
            aluout    = (k == 12) ? 32'h00C0 : 32'h0400 + 32'(k);
            writedata = (k == 12) ? 32'd127 : 32'(k);
            step(1);
        end
        check_value("pause_done", done, 0);
        check_value("pause_running", running, 0);
        idle_inputs();
        rd(5'd0); check_value("pause_cycles", rd_data, 10);
        rd(5'd1); check_value("pause_ev0", rd_data, 10);
        rd(5'd2); check_value("pause_ev1", rd_data, 0);
        rd(5'd5); check_value("pause_stores", rd_data, 10);
        enable = 1'b1; step(1);
        check_value("resume_running", running, 1);
        clear = 1'b1; memwrite = 1'b1; aluout = 32'h00C0; writedata = 32'd127;
        step(1);
        check_value("clrmatch_running", running, 0);
        check_value("clrmatch_done", done, 0);
        clear = 1'b0; enable = 1'b0; idle_inputs();
        step(1);
        check_value("clrmatch_done_late", done, 0);
        rd(5'd0); check_value("clrmatch_cycles", rd_data, 0);
        rd(5'd5); check_value("clrmatch_stores", rd_data, 0);
        check_value("clrmatch_ovf", 32'(ovf), 0);

        // 4-bit counters: 15 increments reach the top, 5 more overflow
        enable = 1'b1; step(1);
        for (int k = 0; k < 15; k++) begin
            enable = (k != 14);
            step(1);
        end
        rd(5'd0);
        check_value("sat_at_15", rd_data_s, 15);
        check_value("wrap_at_15", rd_data_w, 15);
        check_value("sat_ovf_at_15", ovf_s[0], 0);
        check_value("wrap_ovf_at_15", ovf_w[0], 0);
        enable = 1'b1; step(1);
        for (int k = 0; k < 5; k++) begin
            enable = (k != 4);
            step(1);
        end
        rd(5'd0);
        check_value("sat_cycles", rd_data_s, 15);
        check_value("wrap_cycles", rd_data_w, 4);
        check_value("sat_ovf0", ovf_s[0], 1);
        check_value("wrap_ovf0", ovf_w[0], 1);
        check_value("sat_ovf1", ovf_s[1], 0);
        check_value("main_cycles20", rd_data, 20);
        check_value("main_ovf", 32'(ovf), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_perf_monitor.md
Name: mips_perf_monitor

Overview:
Synthesizable, parametrised performance monitor attached to the MIPS core's data-memory interface and pipeline event strobes. Counts cycles, per-channel pipeline events (stall, nop, flush, ...) and memory stores. Detects a programmable completion store (address/data match) and freezes all counters on it. Counters are read through a registered select port, so benches and on-chip debug logic share one mechanism.

Parameters:
WIDTH, 32, data/address width of the memory interface
NEVENTS, 4, number of event input channels (1..16)
CNTBITS, 32, width of every counter
SATURATE, 1, 1 = counters stick at all-ones; 0 = counters wrap to zero
ADDRBITS, 16, low address bits compared for completion match

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
enable  input  1  counting permitted (RUN when high, PAUSE when low)
clear  input  1  synchronous clear of counters/flags, return to IDLE
events  input  NEVENTS  per-channel event strobes, one count per high cycle
memwrite  input  1  data-memory write strobe
aluout  input  WIDTH  store byte address
writedata  input  WIDTH  store data
done_addr  input  ADDRBITS  completion-match address (byte address)
done_data  input  WIDTH  completion-match data
rd_sel  input  5  counter select: 0 = cycles, 1..NEVENTS = events[sel-1], NEVENTS+1 = stores, others = 0
rd_data  output  CNTBITS  selected counter, registered
ovf  output  NEVENTS+2  sticky saturation/wrap flag per counter (bit order as rd_sel)
done  output  1  completion store seen; counters frozen
running  output  1  state == RUN

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; all counters, ovf, done, rd_data = 0. Reset mid-run discards everything.
- States: IDLE, RUN, PAUSE, DONE.
  - IDLE -> RUN when enable=1.
  - RUN -> PAUSE when enable=0.
  - PAUSE -> RUN when enable=1.
  - RUN -> DONE on match.
  - Any state -> IDLE on clear=1.
- clear has priority over match and enable in the same cycle. clear zeroes counters, ovf and done.
- Counting occurs only in cycles where state==RUN at the clock edge:
  - cycle counter +1 every RUN cycle.
  - event[i] counter +1 when events[i]=1.
  - store counter +1 when memwrite=1.
- Match: state==RUN && memwrite && aluout[ADDRBITS-1:0]==done_addr && writedata==done_data.
  - The matching cycle itself is counted (cycle, events, the store).
  - done=1 from the next cycle. Counters are frozen in DONE.
  - done stays high until clear or rst.
- Match is ignored in IDLE/PAUSE. Stores in PAUSE are not counted.
- Overflow: an increment of an all-ones counter sets its ovf bit.
  - SATURATE=1: value holds at all-ones.
  - SATURATE=0: value wraps to 0.
  - ovf bits are sticky until clear/rst.
- Read port: rd_data <= counter[rd_sel] every cycle, giving 1-cycle latency. rd_data reflects the counter value before that edge's increment. Out-of-range rd_sel reads 0. Reads work in all states.
- Arithmetic is unsigned; compare widths are exact, with no sign extension.

Decomposition:
- Shared package mips_perf_pkg: state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3), rd_sel index constants (SEL_CYCLES=0, SEL_EVENT_BASE=1, SEL_STORES function of NEVENTS).
- One sub-module, perf_counter, instantiated NEVENTS+2 times:
  - inputs: clk, rst, clr, inc.
  - outputs: count, ovf.
  - parameters: CNTBITS, SATURATE.
  - holds the saturate/wrap logic.

Test Plan:
- Reset: rst high 10 cycles, enable=1 -> all rd_sel reads 0, done=0, running=0; one cycle after rst falls running=1.
- Basic count: enable 100 cycles, events[0] high every 4th cycle, 10 stores, no match -> cycles=100, event0=25, stores=10, done=0.
- Completion: done_addr=16'h00C0, done_data=127; store 127 to 0xC0 at RUN cycle 50; further stores/events afterwards -> done=1 at cycle 51, cycles=50, stores includes the matching store, values unchanged 20 cycles later. Near miss (addr 0xC0, data 126) does not match.
- Pause/clear priority: enable low 30 cycles mid-run with stores and a matching store -> counters unchanged, done=0. Then clear and match asserted in the same cycle -> state IDLE, all zero, done=0.
- Overflow: CNTBITS=4, SATURATE=1, 20 RUN cycles -> cycles=15, ovf[0]=1. Repeat with SATURATE=0 -> cycles=4, ovf[0]=1.
- Read port: rd_sel=NEVENTS+1 then 31 -> rd_data equals store count one cycle later, then 0.
